// File: rtl/spi_reg_target_if.sv
// SPI bus between an initiator (master) and the register target (slave).
// miso_oe lets a 3-wire board share one data pin between the two directions.
interface spi_reg_target_if;
  logic sclk;
  logic cs_n;
  logic mosi;
  logic miso;
  logic miso_oe;

  modport master (
    output sclk,
    output cs_n,
    output mosi,
    input  miso,
    input  miso_oe
  );

  modport slave (
    input  sclk,
    input  cs_n,
    input  mosi,
    output miso,
    output miso_oe
  );
endinterface

// File: rtl/spi_reg_target.sv
// SPI mode-3 register target: a 128 x 8 register file reachable from an SPI
// initiator (header byte = R/W + address, then data bytes) and from a local
// write port. Everything runs on clk; the SPI pins are oversampled.
module spi_reg_target #(
  parameter logic [6:0] WHOAMI_ADDR  = 7'h0F,
  parameter logic [7:0] WHOAMI_VALUE = 8'hBC,
  parameter bit         AUTO_INC     = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  spi_reg_target_if.slave spi,
  input  logic [6:0]      reg_addr,
  input  logic [7:0]      reg_wdata,
  input  logic            reg_we,
  output logic [7:0]      reg_rdata,
  output logic            evt_wr,
  output logic            evt_rd,
  output logic [6:0]      evt_addr,
  output logic [7:0]      evt_data,
  output logic            busy,
  output logic            frame_err
);

  typedef enum logic [1:0] {StIdle, StHeader, StData} state_e;

  logic [1:0] sclk_sync, cs_sync, mosi_sync;
  logic       sclk_prev, cs_prev;
  logic       sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [1:0] arm_cnt;
  logic       cs_armed;

  state_e     state;
  logic [2:0] bit_cnt;
  logic [6:0] rx_shift;
  logic [7:0] rx_byte;
  logic [7:0] tx_shift;
  logic       tx_hold;
  logic       rw;
  logic [6:0] addr;
  logic [6:0] next_addr;
  logic       miso_oe_q;
  logic [7:0] mem [128];

  function automatic logic [7:0] rd_mem(input logic [6:0] a);
    return (a == WHOAMI_ADDR) ? WHOAMI_VALUE : mem[a];
  endfunction

  assign sclk_rise = sclk_sync[1] & ~sclk_prev;
  assign sclk_fall = ~sclk_sync[1] & sclk_prev;
  assign cs_rise   = cs_sync[1] & ~cs_prev;
  assign cs_fall   = ~cs_sync[1] & cs_prev;
  assign rx_byte   = {rx_shift, mosi_sync[1]};
  assign next_addr = AUTO_INC ? addr + 7'd1 : addr;

  assign busy        = (state != StIdle);
  assign spi.miso    = miso_oe_q & tx_shift[7];
  assign spi.miso_oe = miso_oe_q;

  // Two-flop synchronizers plus one delayed copy for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync <= 2'b11;
      cs_sync   <= 2'b11;
      mosi_sync <= 2'b00;
      sclk_prev <= 1'b1;
      cs_prev   <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[0], spi.sclk};
      cs_sync   <= {cs_sync[0], spi.cs_n};
      mosi_sync <= {mosi_sync[0], spi.mosi};
      sclk_prev <= sclk_sync[1];
      cs_prev   <= cs_sync[1];
    end
  end

  // The synchronizers restart at 1 after reset, so a cs_n held low through
  // reset would look like a fresh falling edge; only accept a frame start once
  // cs_n has been seen high with real (post-reset) synchronized data.
  always_ff @(posedge clk) begin
    if (reset) begin
      arm_cnt  <= 2'd0;
      cs_armed <= 1'b0;
    end else if (arm_cnt != 2'd2) begin
      arm_cnt <= arm_cnt + 2'd1;
    end else if (cs_sync[1]) begin
      cs_armed <= 1'b1;
    end
  end

  // Frame FSM, register file writes and event outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= StIdle;
      bit_cnt   <= 3'd0;
      rx_shift  <= 7'd0;
      tx_shift  <= 8'd0;
      tx_hold   <= 1'b0;
      rw        <= 1'b0;
      addr      <= 7'd0;
      miso_oe_q <= 1'b0;
      evt_wr    <= 1'b0;
      evt_rd    <= 1'b0;
      evt_addr  <= 7'd0;
      evt_data  <= 8'd0;
      frame_err <= 1'b0;
      for (int i = 0; i < 128; i++) mem[i] <= 8'h00;
    end else begin
      evt_wr    <= 1'b0;
      evt_rd    <= 1'b0;
      frame_err <= 1'b0;
      // Local write first so a same-cycle SPI write to the same entry wins.
      if (reg_we && reg_addr != WHOAMI_ADDR) mem[reg_addr] <= reg_wdata;
      if (cs_rise) begin
        if (state != StIdle && bit_cnt != 3'd0) frame_err <= 1'b1;
        state     <= StIdle;
        bit_cnt   <= 3'd0;
        tx_hold   <= 1'b0;
        miso_oe_q <= 1'b0;
      end else begin
        unique case (state)
          StIdle: begin
            if (cs_fall && cs_armed) begin
              state   <= StHeader;
              bit_cnt <= 3'd0;
            end
          end
          StHeader: begin
            if (sclk_rise) begin
              rx_shift <= rx_byte[6:0];
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                rw    <= rx_byte[7];
                addr  <= rx_byte[6:0];
                state <= StData;
                if (rx_byte[7]) begin
                  tx_shift  <= rd_mem(rx_byte[6:0]);
                  tx_hold   <= 1'b1;
                  miso_oe_q <= 1'b1;
                  evt_rd    <= 1'b1;
                  evt_addr  <= rx_byte[6:0];
                  evt_data  <= rd_mem(rx_byte[6:0]);
                end
              end
            end
          end
          StData: begin
            if (sclk_rise) begin
              rx_shift <= rx_byte[6:0];
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                addr <= next_addr;
                if (!rw) begin
                  if (addr != WHOAMI_ADDR) mem[addr] <= rx_byte;
                  evt_wr   <= 1'b1;
                  evt_addr <= addr;
                  evt_data <= rx_byte;
                end else begin
                  // Prefetch the next byte so its MSB is out before the next rise.
                  tx_shift <= rd_mem(next_addr);
                  tx_hold  <= 1'b1;
                  evt_rd   <= 1'b1;
                  evt_addr <= next_addr;
                  evt_data <= rd_mem(next_addr);
                end
              end
            end else if (sclk_fall) begin
              if (tx_hold) tx_hold <= 1'b0;
              else         tx_shift <= {tx_shift[6:0], 1'b0};
            end
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

  // Local read port, one cycle of latency.
  always_ff @(posedge clk) begin
    if (reset) reg_rdata <= 8'd0;
    else       reg_rdata <= rd_mem(reg_addr);
  end

endmodule

// File: tb/tb_spi_reg_target.sv
// Bench for spi_reg_target: directed vector table, hand-written corner
// sequences and randomized SPI frames against a register-file model.
module tb_spi_reg_target;
  localparam logic [6:0] WHO_ADDR = 7'h0F;
  localparam logic [7:0] WHO_VAL  = 8'hBC;
  localparam int         HALF     = 50;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic [7:0] reg_rdata;
  logic       evt_wr, evt_rd, busy, frame_err;
  logic [6:0] evt_addr;
  logic [7:0] evt_data;

  spi_reg_target_if bus ();

  spi_reg_target #(
    .WHOAMI_ADDR (WHO_ADDR),
    .WHOAMI_VALUE(WHO_VAL),
    .AUTO_INC    (1'b1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .spi      (bus.slave),
    .reg_addr (reg_addr),
    .reg_wdata(reg_wdata),
    .reg_we   (reg_we),
    .reg_rdata(reg_rdata),
    .evt_wr   (evt_wr),
    .evt_rd   (evt_rd),
    .evt_addr (evt_addr),
    .evt_data (evt_data),
    .busy     (busy),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  mem_m [128];
  logic [14:0] exp_wr[$], exp_rd[$], got_wr[$], got_rd[$];
  int          fe_cycles = 0;
  logic [7:0]  tx_buf [8];
  logic [7:0]  rx_buf [8];
  logic [7:0]  exp_rx [8];
  logic        oe_last;

  typedef struct {
    logic [7:0] hdr;
    int         n;
    logic [7:0] d0, d1;
    logic [7:0] r0, r1;
    logic       oe;
  } vec_t;
  vec_t tbl [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_rd(input logic [6:0] a);
    return (a == WHO_ADDR) ? WHO_VAL : mem_m[a];
  endfunction

  // Record every event pulse and the number of cycles frame_err is high.
  always @(negedge clk) begin
    if (evt_wr) got_wr.push_back({evt_addr, evt_data});
    if (evt_rd) got_rd.push_back({evt_addr, evt_data});
    if (frame_err) fe_cycles++;
  end

  task automatic send_bits(input int nbits);
    logic [2:0] by, bi;
    for (int i = 0; i < nbits; i++) begin
      by = 3'(i / 8);
      bi = 3'(7 - (i % 8));
      bus.sclk = 1'b0;
      bus.mosi = tx_buf[by][bi];
      #(HALF);
      rx_buf[by][bi] = bus.miso;
      bus.sclk = 1'b1;
      #(HALF);
    end
  endtask

  task automatic spi_frame(input int nbits);
    bus.cs_n = 1'b0;
    #(HALF);
    send_bits(nbits);
    #(HALF);
    oe_last  = bus.miso_oe;
    bus.cs_n = 1'b1;
    #(HALF * 2);
  endtask

  // Reference: read frames return successive bytes and prefetch one extra,
  // write frames store each byte, address increments mod 128 per byte.
  task automatic model_frame(input logic [7:0] hdr, input int n);
    logic [6:0] a;
    a = hdr[6:0];
    if (hdr[7]) begin
      exp_rd.push_back({a, model_rd(a)});
      for (int k = 0; k < n; k++) begin
        exp_rx[k] = model_rd(a);
        a = a + 7'd1;
        exp_rd.push_back({a, model_rd(a)});
      end
    end else begin
      for (int k = 0; k < n; k++) begin
        exp_wr.push_back({a, tx_buf[k + 1]});
        if (a != WHO_ADDR) mem_m[a] = tx_buf[k + 1];
        exp_rx[k] = 8'h00;
        a = a + 7'd1;
      end
    end
  endtask

  task automatic check_events(input string tag);
    check({tag, " evt_wr count"}, 32'(got_wr.size()), 32'(exp_wr.size()));
    check({tag, " evt_rd count"}, 32'(got_rd.size()), 32'(exp_rd.size()));
    while (got_wr.size() > 0 && exp_wr.size() > 0)
      check({tag, " evt_wr payload"}, 32'(got_wr.pop_front()), 32'(exp_wr.pop_front()));
    while (got_rd.size() > 0 && exp_rd.size() > 0)
      check({tag, " evt_rd payload"}, 32'(got_rd.pop_front()), 32'(exp_rd.pop_front()));
    got_wr.delete(); exp_wr.delete(); got_rd.delete(); exp_rd.delete();
  endtask

  task automatic check_rdata(input logic [6:0] a, input string tag);
    @(negedge clk);
    reg_addr = a;
    @(negedge clk);
    check(tag, 32'(reg_rdata), 32'(model_rd(a)));
  endtask

  task automatic local_write(input logic [6:0] a, input logic [7:0] d);
    @(negedge clk);
    reg_addr = a; reg_wdata = d; reg_we = 1'b1;
    @(negedge clk);
    reg_we = 1'b0;
    if (a != WHO_ADDR) mem_m[a] = d;
  endtask

  task automatic run_random_frame(input logic [7:0] hdr, input int n, input string tag);
    tx_buf[0] = hdr;
    model_frame(hdr, n);
    spi_frame(8 * (n + 1));
    for (int k = 0; k < n; k++) check({tag, " rx"}, 32'(rx_buf[k + 1]), 32'(exp_rx[k]));
    check({tag, " miso_oe"}, 32'(oe_last), 32'(hdr[7]));
    check_events(tag);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fe0, n;
    logic [7:0] hdr;
    logic [6:0] a;
    logic seen;

    bus.sclk = 1'b1; bus.cs_n = 1'b1; bus.mosi = 1'b0;
    reg_addr = 7'd0; reg_wdata = 8'd0; reg_we = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 128; i++) mem_m[i] = 8'h00;
    repeat (3) @(negedge clk);
    check("reset miso",      32'(bus.miso),    32'd0);
    check("reset miso_oe",   32'(bus.miso_oe), 32'd0);
    check("reset busy",      32'(busy),        32'd0);
    check("reset frame_err", 32'(frame_err),   32'd0);
    check("reset evt_wr",    32'(evt_wr),      32'd0);
    check("reset evt_rd",    32'(evt_rd),      32'd0);
    check("reset evt_addr",  32'(evt_addr),    32'd0);
    check("reset evt_data",  32'(evt_data),    32'd0);
    check("reset reg_rdata", 32'(reg_rdata),   32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check_rdata(WHO_ADDR, "whoami local read");

    // Directed vectors: {header, bytes, data, expected read data, expected miso_oe}
    tbl[0] = '{hdr: 8'h8F, n: 1, d0: 8'h00, d1: 8'h00, r0: 8'hBC, r1: 8'h00, oe: 1'b1};
    tbl[1] = '{hdr: 8'h20, n: 1, d0: 8'h5A, d1: 8'h00, r0: 8'h00, r1: 8'h00, oe: 1'b0};
    tbl[2] = '{hdr: 8'hA0, n: 1, d0: 8'h00, d1: 8'h00, r0: 8'h5A, r1: 8'h00, oe: 1'b1};
    tbl[3] = '{hdr: 8'h7F, n: 2, d0: 8'h11, d1: 8'h22, r0: 8'h00, r1: 8'h00, oe: 1'b0};
    tbl[4] = '{hdr: 8'hFF, n: 2, d0: 8'h00, d1: 8'h00, r0: 8'h11, r1: 8'h22, oe: 1'b1};
    tbl[5] = '{hdr: 8'h0F, n: 1, d0: 8'h00, d1: 8'h00, r0: 8'h00, r1: 8'h00, oe: 1'b0};
    tbl[6] = '{hdr: 8'h8F, n: 1, d0: 8'h00, d1: 8'h00, r0: 8'hBC, r1: 8'h00, oe: 1'b1};
    for (int i = 0; i < 7; i++) begin
      tx_buf[0] = tbl[i].hdr; tx_buf[1] = tbl[i].d0; tx_buf[2] = tbl[i].d1;
      model_frame(tbl[i].hdr, tbl[i].n);
      spi_frame(8 * (tbl[i].n + 1));
      check($sformatf("vec%0d rx0", i), 32'(rx_buf[1]), 32'(tbl[i].r0));
      if (tbl[i].n > 1) check($sformatf("vec%0d rx1", i), 32'(rx_buf[2]), 32'(tbl[i].r1));
      check($sformatf("vec%0d miso_oe", i), 32'(oe_last), 32'(tbl[i].oe));
      check_events($sformatf("vec%0d", i));
      repeat (3) @(negedge clk);
      check($sformatf("vec%0d miso_oe after cs", i), 32'(bus.miso_oe), 32'd0);
    end
    check_rdata(7'h20, "local read 0x20");
    check_rdata(7'h7F, "local read 0x7F");
    check_rdata(7'h00, "local read 0x00 after wrap");
    check("no frame_err in clean frames", 32'(fe_cycles), 32'd0);

    // Partial data byte: discarded, single-cycle frame_err.
    local_write(7'h10, 8'h77);
    fe0 = fe_cycles;
    tx_buf[0] = 8'h10; tx_buf[1] = 8'hC3;
    spi_frame(12);
    check("partial byte frame_err cycles", 32'(fe_cycles - fe0), 32'd1);
    check("partial byte busy", 32'(busy), 32'd0);
    check_events("partial byte");
    check_rdata(7'h10, "partial byte mem[10]");

    // cs_n rise at a byte boundary or with no bits: no frame_err.
    fe0 = fe_cycles;
    tx_buf[0] = 8'h05;
    spi_frame(8);
    spi_frame(0);
    check("boundary no frame_err", 32'(fe_cycles - fe0), 32'd0);
    check_events("header only");
    tx_buf[0] = 8'h85;
    spi_frame(3);
    check("partial header frame_err", 32'(fe_cycles - fe0), 32'd1);
    check_events("partial header");

    // Same-cycle local and SPI write to 0x30: SPI data must survive.
    tx_buf[0] = 8'h30; tx_buf[1] = 8'h55;
    model_frame(8'h30, 1);
    seen = 1'b0;
    fork
      spi_frame(16);
      begin
        @(negedge clk);
        reg_addr = 7'h30; reg_wdata = 8'hAA; reg_we = 1'b1;
        for (int c = 0; c < 3000 && !evt_wr; c++) @(negedge clk);
        seen = evt_wr;
        reg_we = 1'b0;
      end
    join
    check("conflict evt_wr seen", 32'(seen), 32'd1);
    check_events("conflict");
    check_rdata(7'h30, "conflict mem[30]");

    // Randomized frames and local writes against the model.
    for (int f = 0; f < 25; f++) begin
      a = $urandom_range(0, 1) ? 7'($urandom_range(8, 20)) : 7'($urandom);
      hdr = {1'($urandom), a};
      n = $urandom_range(1, 3);
      for (int k = 1; k <= n; k++) tx_buf[k] = 8'($urandom);
      run_random_frame(hdr, n, $sformatf("rand%0d", f));
      if ($urandom_range(0, 1) == 1) local_write(7'($urandom_range(8, 20)), 8'($urandom));
    end
    for (int i = 0; i < 8; i++) check_rdata(7'($urandom_range(8, 20)), $sformatf("rand rdata%0d", i));
    check("no stray frame_err", 32'(fe_cycles - fe0), 32'd1);

    // Reset in the middle of a header; must wait for a fresh cs_n fall.
    fe0 = fe_cycles;
    tx_buf[0] = 8'h8F; tx_buf[1] = 8'hFF;
    bus.cs_n = 1'b0;
    #(HALF);
    send_bits(3);
    @(negedge clk);
    check("busy before mid-header reset", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("busy after mid-header reset", 32'(busy), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 128; i++) mem_m[i] = 8'h00;
    send_bits(10);
    check("busy with cs held low after reset", 32'(busy), 32'd0);
    bus.cs_n = 1'b1;
    #(HALF * 2);
    check("reset abort no frame_err", 32'(fe_cycles - fe0), 32'd0);
    check_events("reset abort");
    run_random_frame(8'h8F, 1, "post-reset whoami");
    run_random_frame(8'hA0, 1, "post-reset cleared 0x20");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_reg_target.md
SPI_REG_TARGET -- requirements
Module: spi_reg_target

Interface
REQ-001 SHALL have parameter WHOAMI_ADDR, default 7'h0F: read-only identification register address.
REQ-002 SHALL have parameter WHOAMI_VALUE, default 8'hBC: fixed content of WHOAMI_ADDR.
REQ-003 SHALL have parameter AUTO_INC, default 1: 1 = address increments per data byte within a frame; 0 = address fixed.
REQ-004 SHALL have port clk  in  1: sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset  in  1: synchronous, active-high reset.
REQ-006 SHALL have port sclk  in  1: SPI clock from the initiator, mode 3 (idles high), asynchronous to clk.
REQ-007 SHALL have port cs_n  in  1: active-low chip select, asynchronous.
REQ-008 SHALL have port mosi  in  1: serial data from the initiator.
REQ-009 SHALL have port miso  out  1: serial read data.
REQ-010 SHALL have port miso_oe  out  1: 1 = drive miso (3-wire turnaround control).
REQ-011 SHALL have ports reg_addr  in  7, reg_wdata  in  8, reg_we  in  1: local register write port.
REQ-012 SHALL have port reg_rdata  out  8: mem[reg_addr], registered, 1-cycle latency.
REQ-013 SHALL have ports evt_wr  out  1, evt_rd  out  1, evt_addr  out  7, evt_data  out  8: one-cycle SPI access event pulses and their payload.
REQ-014 SHALL have ports busy  out  1 and frame_err  out  1.

Function
REQ-015 SHALL synchronize sclk, cs_n and mosi through two clk flops, then edge-detect sclk and cs_n; operation is required for f_clk >= 8 x f_sclk.
REQ-016 SHALL hold a 128 x 8 register file; WHOAMI_ADDR always reads WHOAMI_VALUE.
REQ-017 SHALL implement states IDLE, HEADER and DATA; busy = 1 in HEADER and DATA.
REQ-018 IDLE -> HEADER on the synchronized cs_n falling edge, with the bit counter cleared.
REQ-019 SHALL sample mosi on each synchronized sclk rising edge, MSB first; header bit 7 is R/W (1 = read) and bits 6:0 are the address.
REQ-020 HEADER -> DATA on the 8th rising edge: latch rw and addr, and clear the bit counter.
REQ-021 Read: on the 8th header rising edge, SHALL load tx_shift with mem[addr], set miso_oe = 1, and pulse evt_rd with evt_addr = addr and evt_data = loaded byte.
REQ-022 miso = tx_shift[7] while miso_oe = 1, else 0.
REQ-023 tx_shift SHALL shift left on each sclk falling edge in DATA, except the first falling edge after a byte load, so bit 7 is presented before the first data rising edge.
REQ-024 Write: on the 8th data rising edge, SHALL write mem[addr] <= received byte and pulse evt_wr with addr and data.
REQ-025 A write to WHOAMI_ADDR SHALL leave mem unchanged but still pulse evt_wr.
REQ-026 After each complete data byte, the address SHALL become addr+1 mod 128 (7'h7F wraps to 7'h00) if AUTO_INC = 1, and DATA continues.
REQ-027 On a read, the next byte SHALL be reloaded on that same 8th rising edge, with a new evt_rd pulse.
REQ-028 Local write port: reg_we writes reg_wdata to mem[reg_addr], except WHOAMI_ADDR.
REQ-029 If an SPI write and reg_we target the same address in the same cycle, the SPI write SHALL win.
REQ-030 The cs_n rising edge in any state SHALL return to IDLE and clear miso_oe within 1 cycle.
REQ-031 A partial byte (bit counter != 0) at a cs_n rising edge SHALL be discarded with no write and SHALL pulse frame_err for 1 cycle.
REQ-032 A cs_n rising edge in HEADER with 0 bits received, or in DATA at a byte boundary, SHALL NOT raise frame_err.
REQ-033 sclk edges while in IDLE SHALL be ignored.

Reset
REQ-034 On reset: state IDLE; mem all 8'h00 except WHOAMI_ADDR.
REQ-035 On reset: miso, miso_oe, busy, frame_err, evt_wr, evt_rd = 0; evt_addr, evt_data = 0.
REQ-036 On reset: reg_rdata = 0; synchronizer flops = 1 (sclk and cs_n idle).
REQ-037 Reset asserted mid-frame SHALL abort the frame with no write and no frame_err; the module SHALL wait for a new cs_n falling edge.

Verification
REQ-038 SPI read header 8'h8F -> miso shifts 8'hBC, evt_rd pulse with evt_addr = 7'h0F, miso_oe = 1 until cs_n rises.
REQ-039 SPI write 8'h20, 8'h5A then read 8'hA0 -> evt_wr (0x20, 0x5A), read returns 8'h5A, reg_rdata = 8'h5A one cycle after reg_addr = 7'h20.
REQ-040 Burst write header 8'h7F with data 8'h11, 8'h22 -> mem[7F] = 11, mem[00] = 22, two evt_wr pulses.
REQ-041 cs_n raised after 4 data bits of a write to 0x10 -> mem[10] unchanged, frame_err = 1 for 1 cycle, state IDLE.
REQ-042 Same-cycle reg_we (0x30, 0xAA) and SPI write (0x30, 0x55) -> mem[30] = 0x55.
REQ-043 Write 8'h0F with data 8'h00 -> evt_wr pulses, read-back of WHOAMI_ADDR is still 8'hBC; reset asserted mid-header -> busy = 0 next cycle.
